// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared ALU opcode encodings and sequencer state encoding
package alu_sequencer_pkg;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_MUL = 4'd9;
    localparam logic [3:0] ALU_DIV = 4'd10;
    localparam logic [3:0] ALU_MOD = 4'd11;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_RD_A,
        SEQ_RD_B,
        SEQ_EXEC,
        SEQ_WB
    } seq_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return op == ALU_DIV || op == ALU_MOD;
    endfunction
endpackage

// File: rtl/alu_seq_fsm.sv
// alu_seq_fsm: sequencer state machine, request handshake and busy flag
// ports: clk, rst (async, active-high), req_valid in; state, req_ready, busy, accept out
module alu_seq_fsm
    import alu_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output seq_state_e state,
    output logic       req_ready,
    output logic       busy,
    output logic       accept
);
    seq_state_e state_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= SEQ_IDLE;
        else     state <= state_n;

    always_comb begin
        req_ready = state == SEQ_IDLE || state == SEQ_WB;
        busy      = state != SEQ_IDLE;
        accept    = req_valid & req_ready;
        state_n   = SEQ_IDLE;
        case (state)
            SEQ_IDLE, SEQ_WB: state_n = accept ? SEQ_RD_A : SEQ_IDLE;
            SEQ_RD_A:         state_n = SEQ_RD_B;
            SEQ_RD_B:         state_n = SEQ_EXEC;
            SEQ_EXEC:         state_n = SEQ_WB;
            default:          state_n = SEQ_IDLE;
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multicycle front end reading operands, driving the external ALU and writing back
// ports: req_* handshake from control; rf_* single sync read port + write port; alu_* to the ALU;
//        busy, done and err_div0 status
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WORD_SIZE  = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [REG_ADDR_W-1:0] req_rd,
    input  logic [REG_ADDR_W-1:0] req_rs1,
    input  logic [REG_ADDR_W-1:0] req_rs2,
    input  logic                  req_use_imm,
    input  logic [WORD_SIZE-1:0]  req_imm,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [WORD_SIZE-1:0]  rf_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]  rf_wdata,
    output logic [WORD_SIZE-1:0]  alu_a,
    output logic [WORD_SIZE-1:0]  alu_b,
    output logic [3:0]            alu_op,
    input  logic [WORD_SIZE-1:0]  alu_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err_div0
);
    seq_state_e            state;
    logic                  accept, exec, wb, use_imm_q, div0_q;
    logic [3:0]            op_q, op_h;
    logic [REG_ADDR_W-1:0] rd_q, rs1_q, rs2_q;
    logic [WORD_SIZE-1:0]  imm_q, a_q, a_h, b_h, res_q, b_live;

    alu_seq_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .state     (state),
        .req_ready (req_ready),
        .busy      (busy),
        .accept    (accept)
    );

    assign exec   = state == SEQ_EXEC;
    assign wb     = state == SEQ_WB;
    assign b_live = use_imm_q ? imm_q : rf_rdata;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            a_q       <= '0;
            res_q     <= '0;
            div0_q    <= 1'b0;
            a_h       <= '0;
            b_h       <= '0;
            op_h      <= '0;
        end else begin
            if (accept) begin
                op_q      <= req_op;
                rd_q      <= req_rd;
                rs1_q     <= req_rs1;
                rs2_q     <= req_rs2;
                imm_q     <= req_imm;
                use_imm_q <= req_use_imm;
            end
            if (state == SEQ_RD_B) a_q <= rf_rdata;
            if (exec) begin
                res_q  <= alu_out;
                div0_q <= is_div_op(op_q) && b_live == '0;
                a_h    <= a_q;
                b_h    <= b_live;
                op_h   <= op_q;
            end
        end

    // ALU ports show live operands only in EXEC and otherwise replay the last EXEC values
    assign alu_a    = exec ? a_q : a_h;
    assign alu_b    = exec ? b_live : b_h;
    assign alu_op   = exec ? op_q : op_h;
    assign rf_raddr = state == SEQ_RD_A ? rs1_q : rs2_q;
    // state resets asynchronously, so a reset during WB drops the write enable at once
    assign rf_we    = wb & ~div0_q;
    assign rf_waddr = rd_q;
    assign rf_wdata = res_q;
    assign done     = wb;
    assign err_div0 = wb & div0_q;
endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;
    localparam int W  = 64;
    localparam int AW = 5;
    localparam logic [W-1:0] SENT = 64'hDEAD_BEEF;

    logic          clk = 1'b0, rst = 1'b1;
    logic          req_valid = 1'b0, req_use_imm = 1'b0, req_ready;
    logic [3:0]    req_op = '0, alu_op;
    logic [AW-1:0] req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [W-1:0]  req_imm = '0;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic [W-1:0]  rf_rdata, rf_wdata, alu_a, alu_b, alu_out;
    logic          rf_we, busy, done, err_div0;
    logic [W-1:0]  regs [32];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [W-1:0]  poke_data = '0;
    int            total = 0, passed = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WORD_SIZE(W), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_use_imm(req_use_imm), .req_imm(req_imm),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .busy(busy), .done(done), .err_div0(err_div0)
    );

    always @(posedge clk) begin
        if (rf_we) regs[rf_waddr] <= rf_wdata;
        if (poke_en) regs[poke_addr] <= poke_data;
        rf_rdata <= regs[rf_raddr];
    end

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            ALU_XOR: alu_out = alu_a ^ alu_b;
            ALU_NOT: alu_out = ~alu_a;
            ALU_SLL: alu_out = alu_a << alu_b[5:0];
            ALU_SRL: alu_out = alu_a >> alu_b[5:0];
            ALU_SRA: alu_out = $signed(alu_a) >>> alu_b[5:0];
            ALU_MUL: alu_out = alu_a * alu_b;
            ALU_DIV: alu_out = alu_b == '0 ? '1 : alu_a / alu_b;
            ALU_MOD: alu_out = alu_b == '0 ? alu_a : alu_a % alu_b;
            default: alu_out = '0;
        endcase
    end

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] rd, rs1, rs2;
        logic          ui;
        logic [W-1:0]  imm, va, vb, exp;
        logic          div0;
    } vec_t;
    vec_t v [12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic ui, input logic [W-1:0] imm);
        req_valid = 1'b1;
        req_op = op;
        req_rd = rd;
        req_rs1 = rs1;
        req_rs2 = rs2;
        req_use_imm = ui;
        req_imm = imm;
    endtask

    // entered at the negedge of the first cycle after the accept edge; returns at done or after 12 cycles
    task automatic wait_done(output int lat, output logic [AW-1:0] ra1, output logic [AW-1:0] ra2,
                             output logic busy_ok, output logic ready_lo);
        lat = 1;
        busy_ok = 1'b1;
        ready_lo = 1'b1;
        ra1 = rf_raddr;
        ra2 = '0;
        while (!done && lat < 12) begin
            busy_ok &= busy;
            ready_lo &= ~req_ready;
            @(negedge clk);
            lat++;
            if (lat == 2) ra2 = rf_raddr;
        end
        busy_ok &= busy;
    endtask

    int            lat;
    logic [AW-1:0] ra1, ra2;
    logic          bok, rlo, saw_done, saw_we;

    initial begin
        v[0]  = '{ALU_ADD, 5'd3,  5'd1,  5'd2,  1'b0, 64'd0,    64'd7,   64'd5,    64'd12,   1'b0};
        v[1]  = '{ALU_MOD, 5'd4,  5'd1,  5'd6,  1'b1, 64'd9,    64'd100, 64'd0,    64'd1,    1'b0};
        v[2]  = '{ALU_DIV, 5'd5,  5'd1,  5'd2,  1'b0, 64'd0,    64'd8,   64'd0,    SENT,     1'b1};
        v[3]  = '{ALU_SUB, 5'd8,  5'd10, 5'd11, 1'b0, 64'd0,    64'd20,  64'd3,    64'd17,   1'b0};
        v[4]  = '{ALU_XOR, 5'd9,  5'd12, 5'd13, 1'b1, 64'hFF,   64'hF0,  64'h1234, 64'h0F,   1'b0};
        v[5]  = '{ALU_MUL, 5'd13, 5'd14, 5'd15, 1'b0, 64'd0,    64'd6,   64'd7,    64'd42,   1'b0};
        v[6]  = '{ALU_MOD, 5'd16, 5'd17, 5'd18, 1'b1, 64'd0,    64'd10,  64'd3,    SENT,     1'b1};
        v[7]  = '{ALU_NOT, 5'd18, 5'd19, 5'd20, 1'b0, 64'd0,    64'd0,   64'd77,   '1,       1'b0};
        v[8]  = '{ALU_DIV, 5'd21, 5'd22, 5'd23, 1'b0, 64'd0,    64'd100, 64'd7,    64'd14,   1'b0};
        v[9]  = '{ALU_DIV, 5'd24, 5'd25, 5'd26, 1'b1, 64'd5,    64'd50,  64'd0,    64'd10,   1'b0};
        v[10] = '{ALU_SRA, 5'd27, 5'd28, 5'd29, 1'b1, 64'd4,
                  64'hF000_0000_0000_0000, 64'd0, 64'hFF00_0000_0000_0000, 1'b0};
        v[11] = '{ALU_SUB, 5'd30, 5'd31, 5'd0,  1'b0, 64'd0,    64'd0,   64'd1,    '1,       1'b0};

        repeat (2) @(negedge clk);
        chk("rst_ready", W'(req_ready), 64'd1);
        chk("rst_busy", W'(busy), 64'd0);
        chk("rst_we", W'(rf_we), 64'd0);
        chk("rst_done", W'(done), 64'd0);
        chk("rst_err", W'(err_div0), 64'd0);
        chk("rst_raddr", W'(rf_raddr), 64'd0);
        chk("rst_waddr", W'(rf_waddr), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        chk("rst_alu_op", W'(alu_op), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            poke(v[i].rs1, v[i].va);
            poke(v[i].rs2, v[i].vb);
            poke(v[i].rd, SENT);
            @(negedge clk);
            drive(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].ui, v[i].imm);
            @(negedge clk);
            req_valid = 1'b0;
            wait_done(lat, ra1, ra2, bok, rlo);
            chk($sformatf("v%0d_latency", i), W'(lat), 64'd4);
            chk($sformatf("v%0d_raddr_rs1", i), W'(ra1), W'(v[i].rs1));
            chk($sformatf("v%0d_raddr_rs2", i), W'(ra2), W'(v[i].rs2));
            chk($sformatf("v%0d_busy", i), W'(bok), 64'd1);
            chk($sformatf("v%0d_ready_low", i), W'(rlo), 64'd1);
            chk($sformatf("v%0d_we", i), W'(rf_we), W'(!v[i].div0));
            chk($sformatf("v%0d_err", i), W'(err_div0), W'(v[i].div0));
            chk($sformatf("v%0d_waddr", i), W'(rf_waddr), W'(v[i].rd));
            if (!v[i].div0) chk($sformatf("v%0d_wdata", i), rf_wdata, v[i].exp);
            @(negedge clk);
            chk($sformatf("v%0d_reg", i), regs[v[i].rd], v[i].exp);
            chk($sformatf("v%0d_idle", i), W'(busy), 64'd0);
        end

        poke(5'd1, 64'd9);
        poke(5'd2, 64'd4);
        poke(5'd3, SENT);
        poke(5'd6, SENT);
        @(negedge clk);
        drive(ALU_SUB, 5'd3, 5'd1, 5'd2, 1'b0, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(lat, ra1, ra2, bok, rlo);
        chk("b2b_gap", W'(lat), 64'd4);
        chk("b2b_wb_ready", W'(req_ready), 64'd1);
        chk("b2b_sub_wdata", rf_wdata, 64'd5);
        drive(ALU_ADD, 5'd6, 5'd3, 5'd3, 1'b0, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_r3", regs[3], 64'd5);
        chk("b2b_second_busy", W'(busy), 64'd1);
        wait_done(lat, ra1, ra2, bok, rlo);
        chk("b2b_add_latency", W'(lat), 64'd4);
        chk("b2b_add_waddr", W'(rf_waddr), 64'd6);
        chk("b2b_add_wdata", rf_wdata, 64'd10);
        @(negedge clk);
        chk("b2b_r6", regs[6], 64'd10);

        poke(5'd28, 64'd3);
        poke(5'd29, 64'd4);
        poke(5'd27, SENT);
        poke(5'd30, SENT);
        poke(5'd10, 64'd20);
        poke(5'd11, 64'd6);
        @(negedge clk);
        drive(ALU_ADD, 5'd27, 5'd28, 5'd29, 1'b0, 64'd0);
        @(negedge clk);
        drive(ALU_SUB, 5'd30, 5'd10, 5'd11, 1'b0, 64'd0);
        wait_done(lat, ra1, ra2, bok, rlo);
        chk("hold_latency", W'(lat), 64'd4);
        chk("hold_ready_low", W'(rlo), 64'd1);
        chk("hold_raddr_rs1", W'(ra1), 64'd28);
        chk("hold_waddr", W'(rf_waddr), 64'd27);
        chk("hold_wdata", rf_wdata, 64'd7);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_wb_accept", W'(busy), 64'd1);
        wait_done(lat, ra1, ra2, bok, rlo);
        chk("hold2_waddr", W'(rf_waddr), 64'd30);
        chk("hold2_wdata", rf_wdata, 64'd14);
        @(negedge clk);
        chk("hold_r27", regs[27], 64'd7);
        chk("hold_r30", regs[30], 64'd14);

        poke(5'd1, 64'd9);
        poke(5'd2, 64'd4);
        poke(5'd7, SENT);
        @(negedge clk);
        drive(ALU_ADD, 5'd7, 5'd1, 5'd2, 1'b0, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("exec_busy", W'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("exec_rst_busy", W'(busy), 64'd0);
        chk("exec_rst_ready", W'(req_ready), 64'd1);
        chk("exec_rst_alu_a", alu_a, 64'd0);
        chk("exec_rst_wdata", rf_wdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        saw_we = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_done |= done;
            saw_we |= rf_we;
        end
        chk("exec_rst_no_done", W'(saw_done), 64'd0);
        chk("exec_rst_no_we", W'(saw_we), 64'd0);
        chk("exec_rst_r7", regs[7], SENT);
        drive(ALU_ADD, 5'd7, 5'd1, 5'd2, 1'b0, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(lat, ra1, ra2, bok, rlo);
        chk("after_rst_latency", W'(lat), 64'd4);
        chk("after_rst_wdata", rf_wdata, 64'd13);
        @(negedge clk);
        chk("after_rst_r7", regs[7], 64'd13);

        poke(5'd7, SENT);
        @(negedge clk);
        drive(ALU_ADD, 5'd7, 5'd1, 5'd2, 1'b0, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(lat, ra1, ra2, bok, rlo);
        chk("wb_we_before_rst", W'(rf_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("wb_rst_we", W'(rf_we), 64'd0);
        chk("wb_rst_done", W'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("wb_rst_r7", regs[7], SENT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
